mem_arbiter: RTL and testbench

- Shares one downstream memory port between the core's instruction fetch (imem) and load/store (dmem) interfaces.
- Sits between core and a single-ported memory/peripheral bus, on the same imem/dmem signal set the core already drives.
- One outstanding transaction at a time; arbitration is round-robin or fixed dmem priority.
- A per-transaction watchdog completes hung accesses with an error word.

---
 rtl/mem_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one downstream memory port between imem fetch and dmem load/store
module mem_arbiter #(
    parameter int          ARB_MODE       = 0,
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] imem_address,
    input  logic        imem_enable,
    output logic [31:0] imem_data,
    output logic        imem_wait,
    input  logic [31:0] dmem_address,
    input  logic        dmem_enable,
    input  logic [31:0] dmem_write_data,
    input  logic        dmem_write_enable,
    input  logic [2:0]  dmem_write_mode,
    input  logic        dmem_read_enable,
    input  logic [2:0]  dmem_read_mode,
    output logic [31:0] dmem_read_data,
    output logic        dmem_wait,
    output logic [31:0] mem_address,
    output logic        mem_enable,
    output logic        mem_write_enable,
    output logic [31:0] mem_write_data,
    output logic [2:0]  mem_write_mode,
    output logic        mem_read_enable,
    output logic [2:0]  mem_read_mode,
    input  logic        mem_wait,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_read_data,
    output logic        bus_error
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic        GRANT_IMEM  = 1'b0;
    localparam logic        GRANT_DMEM  = 1'b1;
    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);
    localparam bit          WDOG_EN     = (TIMEOUT_CYCLES != 0);
    localparam logic [2:0]  FETCH_MODE  = 3'b010;

    state_t      state, state_next;
    logic        grant, grant_next;
    logic        last_grant, last_grant_next;
    logic [31:0] cmd_address, cmd_address_next;
    logic [31:0] cmd_write_data, cmd_write_data_next;
    logic [2:0]  cmd_write_mode, cmd_write_mode_next;
    logic [2:0]  cmd_read_mode, cmd_read_mode_next;
    logic        cmd_write_enable, cmd_write_enable_next;
    logic        cmd_read_enable, cmd_read_enable_next;
    logic [31:0] rdata_q, rdata_next;
    logic [15:0] timer, timer_next;
    logic        bus_error_q, bus_error_next;
    logic        issue_active;
    logic        pick_dmem;
    logic        timeout_hit;

    // Round-robin only matters under contention; a lone requester always wins.
    always_comb begin
        pick_dmem = 1'b0;
        if (ARB_MODE == 1) begin
            pick_dmem = dmem_enable;
        end else begin
            pick_dmem = dmem_enable & (~imem_enable | (last_grant == GRANT_IMEM));
        end
    end

    assign timeout_hit = WDOG_EN && ((state == ISSUE) || (state == RESP)) && (timer == TIMEOUT_LIM);

    always_comb begin
        state_next            = state;
        grant_next            = grant;
        last_grant_next       = last_grant;
        cmd_address_next      = cmd_address;
        cmd_write_data_next   = cmd_write_data;
        cmd_write_mode_next   = cmd_write_mode;
        cmd_read_mode_next    = cmd_read_mode;
        cmd_write_enable_next = cmd_write_enable;
        cmd_read_enable_next  = cmd_read_enable;
        rdata_next            = rdata_q;
        timer_next            = timer;
        bus_error_next        = bus_error_q;
        issue_active          = 1'b0;

        case (state)
            IDLE: begin
                if (imem_enable || dmem_enable) begin
                    timer_next = 16'd0;
                    if (pick_dmem) begin
                        grant_next            = GRANT_DMEM;
                        last_grant_next       = GRANT_DMEM;
                        cmd_address_next      = dmem_address;
                        cmd_write_data_next   = dmem_write_data;
                        cmd_write_mode_next   = dmem_write_mode;
                        cmd_read_mode_next    = dmem_read_mode;
                        cmd_write_enable_next = dmem_write_enable;
                        // A combined read+write request is executed as a store.
                        cmd_read_enable_next  = dmem_read_enable & ~dmem_write_enable;
                        if (!dmem_write_enable && !dmem_read_enable) begin
                            rdata_next = 32'd0;
                            state_next = DONE;
                        end else begin
                            state_next = ISSUE;
                        end
                    end else begin
                        grant_next            = GRANT_IMEM;
                        last_grant_next       = GRANT_IMEM;
                        cmd_address_next      = imem_address;
                        cmd_write_data_next   = 32'd0;
                        cmd_write_mode_next   = 3'b000;
                        cmd_read_mode_next    = FETCH_MODE;
                        cmd_write_enable_next = 1'b0;
                        cmd_read_enable_next  = 1'b1;
                        state_next            = ISSUE;
                    end
                end
            end
            ISSUE: begin
                timer_next = timer + 16'd1;
                if (timeout_hit) begin
                    rdata_next     = ERR_DATA;
                    bus_error_next = 1'b1;
                    state_next     = DONE;
                end else begin
                    issue_active = 1'b1;
                    if (!mem_wait) begin
                        state_next = cmd_write_enable ? DONE : RESP;
                    end
                end
            end
            RESP: begin
                timer_next = timer + 16'd1;
                if (timeout_hit) begin
                    rdata_next     = ERR_DATA;
                    bus_error_next = 1'b1;
                    state_next     = DONE;
                end else if (mem_rvalid) begin
                    rdata_next = mem_read_data;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            grant            <= GRANT_IMEM;
            last_grant       <= GRANT_IMEM;
            cmd_address      <= 32'd0;
            cmd_write_data   <= 32'd0;
            cmd_write_mode   <= 3'b000;
            cmd_read_mode    <= 3'b000;
            cmd_write_enable <= 1'b0;
            cmd_read_enable  <= 1'b0;
            rdata_q          <= 32'd0;
            timer            <= 16'd0;
            bus_error_q      <= 1'b0;
        end else begin
            state            <= state_next;
            grant            <= grant_next;
            last_grant       <= last_grant_next;
            cmd_address      <= cmd_address_next;
            cmd_write_data   <= cmd_write_data_next;
            cmd_write_mode   <= cmd_write_mode_next;
            cmd_read_mode    <= cmd_read_mode_next;
            cmd_write_enable <= cmd_write_enable_next;
            cmd_read_enable  <= cmd_read_enable_next;
            rdata_q          <= rdata_next;
            timer            <= timer_next;
            bus_error_q      <= bus_error_next;
        end
    end

    assign mem_enable       = issue_active;
    assign mem_write_enable = issue_active & cmd_write_enable;
    assign mem_read_enable  = issue_active & cmd_read_enable;
    assign mem_address      = cmd_address;
    assign mem_write_data   = cmd_write_data;
    assign mem_write_mode   = cmd_write_mode;
    assign mem_read_mode    = cmd_read_mode;

    // Completion is only visible while the requester still holds enable.
    assign imem_wait      = imem_enable & ~((state == DONE) && (grant == GRANT_IMEM));
    assign dmem_wait      = dmem_enable & ~((state == DONE) && (grant == GRANT_DMEM));
    assign imem_data      = rdata_q;
    assign dmem_read_data = rdata_q;
    assign bus_error      = bus_error_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter
module tb_mem_arbiter;

    typedef struct {
        bit          port;
        logic [31:0] data;
        bit          chk;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sel1 = 1'b0;
    logic [31:0] imem_address = 32'd0;
    logic        imem_enable = 1'b0;
    logic [31:0] dmem_address = 32'd0;
    logic        dmem_enable = 1'b0;
    logic [31:0] dmem_write_data = 32'd0;
    logic        dmem_write_enable = 1'b0;
    logic [2:0]  dmem_write_mode = 3'b000;
    logic        dmem_read_enable = 1'b0;
    logic [2:0]  dmem_read_mode = 3'b000;

    wire imem_enable0 = imem_enable & ~sel1;
    wire dmem_enable0 = dmem_enable & ~sel1;
    wire imem_enable1 = imem_enable & sel1;
    wire dmem_enable1 = dmem_enable & sel1;

    logic [31:0] imem_data0, dmem_read_data0, mem_address0, mem_write_data0;
    logic        imem_wait0, dmem_wait0, mem_enable0, mem_write_enable0, mem_read_enable0, bus_error0;
    logic [2:0]  mem_write_mode0, mem_read_mode0;
    logic        mem_wait0 = 1'b0;
    logic        mem_rvalid0 = 1'b0;
    logic [31:0] mem_read_data0 = 32'd0;

    logic [31:0] imem_data1, dmem_read_data1, mem_address1, mem_write_data1;
    logic        imem_wait1, dmem_wait1, mem_enable1, mem_write_enable1, mem_read_enable1, bus_error1;
    logic [2:0]  mem_write_mode1, mem_read_mode1;
    logic        mem_wait1 = 1'b0;
    logic        mem_rvalid1 = 1'b0;
    logic [31:0] mem_read_data1 = 32'd0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int issue_cnt = 0;
    exp_t q0[$];
    exp_t q1[$];

    int          stall_cycles = 0;
    bit          resp_on = 1'b1;
    int          inject_cycle = -1;
    int          issue_run = 0;
    bit          rv_pend0 = 1'b0;
    logic [31:0] rv_data0 = 32'd0;
    bit          rv_pend1 = 1'b0;
    logic [31:0] rv_data1 = 32'd0;

    bit          cmd_chk_en = 1'b1;
    logic [31:0] exp_addr = 32'd0;
    logic [31:0] exp_wdata = 32'd0;
    logic        exp_we = 1'b0;
    logic        exp_re = 1'b0;
    logic [2:0]  exp_wmode = 3'b000;
    logic [2:0]  exp_rmode = 3'b000;

    mem_arbiter #(.ARB_MODE(0), .TIMEOUT_CYCLES(8), .ERR_DATA(32'hDEADBEEF)) dut0 (
        .clk(clk), .reset_n(reset_n),
        .imem_address(imem_address), .imem_enable(imem_enable0),
        .imem_data(imem_data0), .imem_wait(imem_wait0),
        .dmem_address(dmem_address), .dmem_enable(dmem_enable0),
        .dmem_write_data(dmem_write_data), .dmem_write_enable(dmem_write_enable),
        .dmem_write_mode(dmem_write_mode), .dmem_read_enable(dmem_read_enable),
        .dmem_read_mode(dmem_read_mode), .dmem_read_data(dmem_read_data0), .dmem_wait(dmem_wait0),
        .mem_address(mem_address0), .mem_enable(mem_enable0),
        .mem_write_enable(mem_write_enable0), .mem_write_data(mem_write_data0),
        .mem_write_mode(mem_write_mode0), .mem_read_enable(mem_read_enable0),
        .mem_read_mode(mem_read_mode0), .mem_wait(mem_wait0), .mem_rvalid(mem_rvalid0),
        .mem_read_data(mem_read_data0), .bus_error(bus_error0)
    );

    mem_arbiter #(.ARB_MODE(1), .TIMEOUT_CYCLES(1024), .ERR_DATA(32'hDEADBEEF)) dut1 (
        .clk(clk), .reset_n(reset_n),
        .imem_address(imem_address), .imem_enable(imem_enable1),
        .imem_data(imem_data1), .imem_wait(imem_wait1),
        .dmem_address(dmem_address), .dmem_enable(dmem_enable1),
        .dmem_write_data(dmem_write_data), .dmem_write_enable(dmem_write_enable),
        .dmem_write_mode(dmem_write_mode), .dmem_read_enable(dmem_read_enable),
        .dmem_read_mode(dmem_read_mode), .dmem_read_data(dmem_read_data1), .dmem_wait(dmem_wait1),
        .mem_address(mem_address1), .mem_enable(mem_enable1),
        .mem_write_enable(mem_write_enable1), .mem_write_data(mem_write_data1),
        .mem_write_mode(mem_write_mode1), .mem_read_enable(mem_read_enable1),
        .mem_read_mode(mem_read_mode1), .mem_wait(mem_wait1), .mem_rvalid(mem_rvalid1),
        .mem_read_data(mem_read_data1), .bus_error(bus_error1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return (a == 32'h100) ? 32'h00000013 : (a ^ 32'h13579BDF);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic sb_pop(input bit which, input bit port, input logic [31:0] data);
        exp_t e;
        bit   empty;
        empty = which ? (q1.size() == 0) : (q0.size() == 0);
        if (empty) begin
            checks++;
            errors++;
            $display("FAIL unexpected_completion: dut%0d port %0d data %h at cycle %0d, expected none", which, port, data, cyc);
        end else begin
            if (which) e = q1.pop_front();
            else       e = q0.pop_front();
            check("compl_port", 32'(port), 32'(e.port));
            if (e.chk) check("compl_data", data, e.data);
            check("compl_cycle", 32'(cyc), 32'(e.cyc));
        end
    endtask

    // Downstream model for dut0: programmable stall, read data one cycle after accept.
    always @(negedge clk) begin
        mem_rvalid0    = rv_pend0 || (cyc == inject_cycle);
        mem_read_data0 = rv_pend0 ? rv_data0 : 32'hBADBAD00;
        rv_pend0       = 1'b0;
        if (mem_enable0) begin
            mem_wait0 = (issue_run < stall_cycles);
            if (!mem_wait0 && mem_read_enable0 && resp_on) begin
                rv_pend0 = 1'b1;
                rv_data0 = mem_val(mem_address0);
            end
            issue_run++;
        end else begin
            mem_wait0 = 1'b0;
            issue_run = 0;
        end
    end

    always @(negedge clk) begin
        mem_rvalid1    = rv_pend1;
        mem_read_data1 = rv_pend1 ? rv_data1 : 32'd0;
        rv_pend1       = mem_enable1 & mem_read_enable1;
        rv_data1       = mem_val(mem_address1);
    end

    always @(negedge clk) begin
        if (imem_enable0 && !imem_wait0) sb_pop(1'b0, 1'b0, imem_data0);
        if (dmem_enable0 && !dmem_wait0) sb_pop(1'b0, 1'b1, dmem_read_data0);
        if (imem_enable1 && !imem_wait1) sb_pop(1'b1, 1'b0, imem_data1);
        if (dmem_enable1 && !dmem_wait1) sb_pop(1'b1, 1'b1, dmem_read_data1);
    end

    always @(negedge clk) begin
        if (mem_enable0) begin
            issue_cnt++;
            if (cmd_chk_en) begin
                check("mem_address", mem_address0, exp_addr);
                check("mem_write_enable", 32'(mem_write_enable0), 32'(exp_we));
                check("mem_read_enable", 32'(mem_read_enable0), 32'(exp_re));
                if (exp_we) begin
                    check("mem_write_data", mem_write_data0, exp_wdata);
                    check("mem_write_mode", 32'(mem_write_mode0), 32'(exp_wmode));
                end
                if (exp_re) check("mem_read_mode", 32'(mem_read_mode0), 32'(exp_rmode));
            end
        end
    end

    // Issues one request in an IDLE cycle, waits for completion, then idles one cycle.
    task automatic req(input bit port, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic we, input logic re, input logic [2:0] wmode, input logic [2:0] rmode,
                       input int lat, input logic [31:0] exp_data, input bit chk);
        int n;
        bit done;
        exp_addr = addr;
        if (port) begin
            exp_we = we; exp_re = re & ~we; exp_wdata = wdata; exp_wmode = wmode; exp_rmode = rmode;
            dmem_address = addr; dmem_write_data = wdata; dmem_write_enable = we;
            dmem_read_enable = re; dmem_write_mode = wmode; dmem_read_mode = rmode;
            dmem_enable = 1'b1;
        end else begin
            exp_we = 1'b0; exp_re = 1'b1; exp_rmode = 3'b010;
            imem_address = addr;
            imem_enable = 1'b1;
        end
        q0.push_back('{port: port, data: exp_data, chk: chk, cyc: cyc + lat});
        n = 0;
        done = 1'b0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
            done = port ? !dmem_wait0 : !imem_wait0;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL req_timeout: port %0d addr %h got no completion, expected one within 40 cycles", port, addr);
        end
        #1;
        imem_enable = 1'b0;
        dmem_enable = 1'b0;
        @(negedge clk);
        #1;
    endtask

    initial begin
        int base;
        int s;
        imem_enable = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_mem_enable", 32'(mem_enable0), 32'd0);
        check("rst_mem_address", mem_address0, 32'd0);
        check("rst_mem_write_enable", 32'(mem_write_enable0), 32'd0);
        check("rst_mem_read_enable", 32'(mem_read_enable0), 32'd0);
        check("rst_bus_error", 32'(bus_error0), 32'd0);
        check("rst_imem_data", imem_data0, 32'd0);
        check("rst_dmem_read_data", dmem_read_data0, 32'd0);
        check("rst_imem_wait", 32'(imem_wait0), 32'd1);
        check("rst_dmem_wait", 32'(dmem_wait0), 32'd0);
        #1;
        imem_enable = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        #1;

        base = issue_cnt;
        req(1'b0, 32'h100, 32'd0, 1'b0, 1'b1, 3'b000, 3'b000, 3, 32'h00000013, 1'b1);
        check("imem_read_issue_cycles", 32'(issue_cnt - base), 32'd1);

        stall_cycles = 2;
        base = issue_cnt;
        req(1'b1, 32'h2000, 32'hA5A5A5A5, 1'b1, 1'b0, 3'b010, 3'b000, 4, 32'd0, 1'b0);
        check("dmem_write_issue_cycles", 32'(issue_cnt - base), 32'd3);
        stall_cycles = 0;

        base = issue_cnt;
        req(1'b1, 32'h3000, 32'd0, 1'b0, 1'b0, 3'b000, 3'b000, 1, 32'd0, 1'b1);
        check("noop_issue_cycles", 32'(issue_cnt - base), 32'd0);

        req(1'b1, 32'h800, 32'd0, 1'b0, 1'b1, 3'b000, 3'b100, 3, 32'h135793DF, 1'b1);
        req(1'b1, 32'h44, 32'h11223344, 1'b1, 1'b1, 3'b001, 3'b010, 2, 32'd0, 1'b0);

        resp_on = 1'b0;
        req(1'b0, 32'h500, 32'd0, 1'b0, 1'b1, 3'b000, 3'b000, 10, 32'hDEADBEEF, 1'b1);
        check("timeout_bus_error", 32'(bus_error0), 32'd1);
        resp_on = 1'b1;
        req(1'b1, 32'h800, 32'd0, 1'b0, 1'b1, 3'b000, 3'b010, 3, 32'h135793DF, 1'b1);
        check("bus_error_sticky", 32'(bus_error0), 32'd1);

        resp_on = 1'b0;
        exp_addr = 32'h600; exp_we = 1'b0; exp_re = 1'b1; exp_rmode = 3'b010;
        imem_address = 32'h600;
        imem_enable = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("resp_rst_mem_enable", 32'(mem_enable0), 32'd0);
        check("resp_rst_imem_wait", 32'(imem_wait0), 32'd1);
        check("resp_rst_dmem_wait", 32'(dmem_wait0), 32'd0);
        check("resp_rst_bus_error", 32'(bus_error0), 32'd0);
        imem_enable = 1'b0;
        #1;
        check("resp_rst_imem_wait_low", 32'(imem_wait0), 32'd0);
        @(negedge clk);
        #1;
        reset_n = 1'b1;
        resp_on = 1'b1;
        inject_cycle = cyc + 1;
        req(1'b0, 32'h100, 32'd0, 1'b0, 1'b1, 3'b000, 3'b000, 3, 32'h00000013, 1'b1);

        cmd_chk_en = 1'b0;
        s = cyc;
        imem_address = 32'h400;
        dmem_address = 32'h800;
        dmem_read_enable = 1'b1;
        dmem_write_enable = 1'b0;
        dmem_read_mode = 3'b010;
        q0.push_back('{port: 1'b1, data: 32'h135793DF, chk: 1'b1, cyc: s + 3});
        q0.push_back('{port: 1'b0, data: 32'h13579FDF, chk: 1'b1, cyc: s + 7});
        q0.push_back('{port: 1'b1, data: 32'h135793DF, chk: 1'b1, cyc: s + 11});
        q0.push_back('{port: 1'b0, data: 32'h13579FDF, chk: 1'b1, cyc: s + 15});
        imem_enable = 1'b1;
        dmem_enable = 1'b1;
        repeat (15) @(negedge clk);
        #1;
        imem_enable = 1'b0;
        dmem_enable = 1'b0;
        @(negedge clk);
        #1;

        sel1 = 1'b1;
        s = cyc;
        q1.push_back('{port: 1'b1, data: 32'h135793DF, chk: 1'b1, cyc: s + 3});
        q1.push_back('{port: 1'b1, data: 32'h135793DF, chk: 1'b1, cyc: s + 7});
        q1.push_back('{port: 1'b1, data: 32'h135793DF, chk: 1'b1, cyc: s + 11});
        q1.push_back('{port: 1'b0, data: 32'h13579FDF, chk: 1'b1, cyc: s + 15});
        imem_enable = 1'b1;
        dmem_enable = 1'b1;
        repeat (11) @(negedge clk);
        #1;
        dmem_enable = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        imem_enable = 1'b0;
        sel1 = 1'b0;
        repeat (3) @(negedge clk);

        check("q0_drained", 32'(q0.size()), 32'd0);
        check("q1_drained", 32'(q1.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: bench still running at %0t, expected finish earlier", $time);
        $fatal(1, "bench time limit exceeded");
    end

endmodule
